l1_snoop_resp_q: RTL and testbench

L1_SNOOP_RESP_Q -- requirements
Module: l1_snoop_resp_q

---
 rtl/param_pkg.sv | 47 ++++
 rtl/snoop_fifo.sv | 58 +++++
 rtl/l1_snoop_resp_q.sv | 131 +++++++++++++
 tb/tb_l1_snoop_resp_q.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/param_pkg.sv
// Shared widths, snoop opcodes, CRRESP bit positions and FSM states for the L1 snoop responder.
// Also holds the snoop response encoder used by the response FSM.
package param_pkg;

  localparam int ADDR_WIDTH   = 32;
  localparam int DATA_WIDTH   = 64;
  localparam int CRRESP_WIDTH = 5;

  localparam logic [3:0] SNP_READ_ONCE    = 4'h0;
  localparam logic [3:0] SNP_READ_SHARED  = 4'h1;
  localparam logic [3:0] SNP_READ_CLEAN   = 4'h2;
  localparam logic [3:0] SNP_MAKE_INVALID = 4'hD;

  localparam int CR_DATA_XFER  = 0;
  localparam int CR_ERROR      = 1;
  localparam int CR_PASS_DIRTY = 2;
  localparam int CR_IS_SHARED  = 3;
  localparam int CR_WAS_UNIQUE = 4;

  typedef enum logic [2:0] {
    IDLE,
    LOOKUP,
    WAIT_RSP,
    RESP,
    DATA
  } snoop_state_e;

  // MakeInvalid discards the line, so a dirty hit on it never moves data.
  function automatic logic [CRRESP_WIDTH-1:0] calc_crresp(
    input logic [3:0] snoop,
    input logic       hit,
    input logic       dirty,
    input logic       uniq
  );
    logic [CRRESP_WIDTH-1:0] resp;
    resp                = '0;
    resp[CR_DATA_XFER]  = hit && dirty && (snoop != SNP_MAKE_INVALID);
    resp[CR_ERROR]      = 1'b0;
    resp[CR_PASS_DIRTY] = resp[CR_DATA_XFER];
    resp[CR_IS_SHARED]  = hit && ((snoop == SNP_READ_ONCE) ||
                                  (snoop == SNP_READ_SHARED) ||
                                  (snoop == SNP_READ_CLEAN));
    resp[CR_WAS_UNIQUE] = hit && uniq;
    return resp;
  endfunction

endpackage

// File: rtl/snoop_fifo.sv
// Circular FIFO holding pending snoop requests; pointers wrap naturally at the power-of-2 depth.
// Push is refused when full and pop when empty, so the occupancy count never over/underflows.
module snoop_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 36
) (
  input  logic                           clk,
  input  logic                           resetn,
  input  logic                           i_push,
  input  logic [WIDTH-1:0]               i_wdata,
  input  logic                           i_pop,
  output logic [WIDTH-1:0]               o_rdata,
  output logic                           o_full,
  output logic                           o_empty,
  output logic [$clog2(DEPTH+1)-1:0]     o_count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wptr;
  logic [PW-1:0]    r_rptr;
  logic [CW-1:0]    r_count;
  logic             w_push;
  logic             w_pop;

  assign o_full  = (r_count == CW'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign o_rdata = r_mem[r_rptr];
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;

  // NOTE: storage has no reset; entries are only read after being written, and the
  // pointers/count below carry all the state that must be cleared.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= i_wdata;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/l1_snoop_resp_q.sv
// L1 snoop responder: queues AC snoops, looks each up in the cache core, returns CRRESP
// and, for dirty hits that transfer data, streams the line out on CD.
module l1_snoop_resp_q
  import param_pkg::*;
#(
  parameter int AC_DEPTH   = 4,
  parameter int LINE_BEATS = 4
) (
  input  logic                            clk,
  input  logic                            resetn,
  input  logic                            ac_valid,
  input  logic [ADDR_WIDTH-1:0]           ac_addr,
  input  logic [2:0]                      ac_prot,
  input  logic [3:0]                      ac_snoop,
  output logic                            ac_ready,
  output logic                            cr_valid,
  output logic [CRRESP_WIDTH-1:0]         cr_resp,
  input  logic                            cr_ready,
  output logic                            cd_valid,
  output logic [DATA_WIDTH-1:0]           cd_data,
  output logic                            cd_last,
  input  logic                            cd_ready,
  output logic                            lk_valid,
  output logic [ADDR_WIDTH-1:0]           lk_addr,
  output logic [3:0]                      lk_snoop,
  input  logic                            lk_ready,
  input  logic                            lk_rsp_valid,
  input  logic                            lk_hit,
  input  logic                            lk_dirty,
  input  logic                            lk_unique,
  input  logic                            ld_valid,
  input  logic [DATA_WIDTH-1:0]           ld_data,
  output logic                            ld_ready,
  output logic                            busy,
  output logic [$clog2(AC_DEPTH+1)-1:0]   pending
);

  localparam int FW = ADDR_WIDTH + 4;
  localparam int BW = (LINE_BEATS > 1) ? $clog2(LINE_BEATS) : 1;

  snoop_state_e            r_state;
  snoop_state_e            w_state_nxt;
  logic [3:0]              r_snoop;
  logic [CRRESP_WIDTH-1:0] r_cr_resp;
  logic [BW-1:0]           r_beat;
  logic [FW-1:0]           w_fifo_rdata;
  logic                    w_full;
  logic                    w_empty;
  logic                    w_pop;
  logic                    w_last_beat;
  logic                    w_unused_prot;

  // Protection attributes do not affect how a snoop is answered.
  assign w_unused_prot = ^ac_prot;

  snoop_fifo #(
    .DEPTH (AC_DEPTH),
    .WIDTH (FW)
  ) u_fifo (
    .clk     (clk),
    .resetn  (resetn),
    .i_push  (ac_valid),
    .i_wdata ({ac_addr, ac_snoop}),
    .i_pop   (w_pop),
    .o_rdata (w_fifo_rdata),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (pending)
  );

  assign ac_ready    = !w_full;
  assign lk_addr     = w_fifo_rdata[FW-1:4];
  assign lk_snoop    = w_fifo_rdata[3:0];
  assign cd_data     = ld_data;
  assign cr_resp     = r_cr_resp;
  assign busy        = (r_state != IDLE);
  assign w_last_beat = (r_beat == BW'(LINE_BEATS - 1));
  assign cd_last     = (r_state == DATA) && w_last_beat;

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    lk_valid    = 1'b0;
    cr_valid    = 1'b0;
    cd_valid    = 1'b0;
    ld_ready    = 1'b0;
    case (r_state)
      IDLE: begin
        if (!w_empty) w_state_nxt = LOOKUP;
      end
      LOOKUP: begin
        lk_valid = 1'b1;
        if (lk_ready) begin
          w_pop       = 1'b1;
          w_state_nxt = WAIT_RSP;
        end
      end
      WAIT_RSP: begin
        if (lk_rsp_valid) w_state_nxt = RESP;
      end
      RESP: begin
        cr_valid = 1'b1;
        if (cr_ready) w_state_nxt = r_cr_resp[CR_DATA_XFER] ? DATA : IDLE;
      end
      DATA: begin
        cd_valid = ld_valid;
        ld_ready = cd_ready;
        if (ld_valid && cd_ready && w_last_beat) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state   <= IDLE;
      r_snoop   <= '0;
      r_cr_resp <= '0;
      r_beat    <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_pop) r_snoop <= lk_snoop;
      if ((r_state == WAIT_RSP) && lk_rsp_valid)
        r_cr_resp <= calc_crresp(r_snoop, lk_hit, lk_dirty, lk_unique);
      if (cd_valid && cd_ready)
        r_beat <= w_last_beat ? '0 : r_beat + 1'b1;
    end
  end

endmodule

// File: tb/tb_l1_snoop_resp_q.sv
// Self-checking bench for l1_snoop_resp_q: directed vector table, multi-cycle corner
// sequences, and random traffic checked by a transaction-level model on every falling edge.
module tb_l1_snoop_resp_q;

  localparam int AW    = param_pkg::ADDR_WIDTH;
  localparam int DW    = param_pkg::DATA_WIDTH;
  localparam int DEPTH = 4;
  localparam int LB    = 4;

  logic          clk = 1'b0;
  logic          resetn;
  logic          ac_valid, ac_ready;
  logic [AW-1:0] ac_addr;
  logic [2:0]    ac_prot;
  logic [3:0]    ac_snoop;
  logic          cr_valid, cr_ready;
  logic [4:0]    cr_resp;
  logic          cd_valid, cd_last, cd_ready;
  logic [DW-1:0] cd_data;
  logic          lk_valid, lk_ready;
  logic [AW-1:0] lk_addr;
  logic [3:0]    lk_snoop;
  logic          lk_rsp_valid, lk_hit, lk_dirty, lk_unique;
  logic          ld_valid, ld_ready;
  logic [DW-1:0] ld_data;
  logic          busy;
  logic [2:0]    pending;

  l1_snoop_resp_q #(.AC_DEPTH(DEPTH), .LINE_BEATS(LB)) dut (
    .clk(clk), .resetn(resetn),
    .ac_valid(ac_valid), .ac_addr(ac_addr), .ac_prot(ac_prot), .ac_snoop(ac_snoop), .ac_ready(ac_ready),
    .cr_valid(cr_valid), .cr_resp(cr_resp), .cr_ready(cr_ready),
    .cd_valid(cd_valid), .cd_data(cd_data), .cd_last(cd_last), .cd_ready(cd_ready),
    .lk_valid(lk_valid), .lk_addr(lk_addr), .lk_snoop(lk_snoop), .lk_ready(lk_ready),
    .lk_rsp_valid(lk_rsp_valid), .lk_hit(lk_hit), .lk_dirty(lk_dirty), .lk_unique(lk_unique),
    .ld_valid(ld_valid), .ld_data(ld_data), .ld_ready(ld_ready),
    .busy(busy), .pending(pending)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Response rules written straight from the snoop semantics.
  function automatic logic [4:0] ref_resp(input logic [3:0] snp, input logic hit,
                                          input logic dirty, input logic uniq);
    logic xfer, shared, was_u;
    xfer   = hit && dirty && (snp != 4'hD);
    shared = hit && (snp == 4'h0 || snp == 4'h1 || snp == 4'h2);
    was_u  = hit && uniq;
    return {was_u, shared, xfer, 1'b0, xfer};
  endfunction

  // Transaction model: queue of accepted snoops plus the one snoop being answered.
  typedef struct { logic [AW-1:0] addr; logic [3:0] snoop; } ac_t;
  ac_t        mq[$];
  bit         mon_en = 1'b0;
  bit         aw_rsp, aw_cr, in_data;
  int         beat;
  logic [3:0] cur_snoop;
  logic [4:0] exp_resp;

  always @(negedge clk) begin
    if (!mon_en) begin
      mq.delete();
      aw_rsp = 0; aw_cr = 0; in_data = 0; beat = 0;
    end else begin
      check("mon_pending", pending, mq.size());
      check("mon_ac_ready", ac_ready, mq.size() < DEPTH);
      check("mon_cr_valid", cr_valid, aw_cr);
      check("mon_cd_valid", cd_valid, in_data && ld_valid);
      check("mon_ld_ready", ld_ready, in_data && cd_ready);
      check("mon_cd_last", cd_last, in_data && (beat == LB - 1));
      if (in_data && ld_valid) check("mon_cd_data", cd_data, ld_data);
      if (aw_rsp || aw_cr || in_data) check("mon_busy", busy, 1'b1);
      else if (mq.size() == 0) check("mon_idle", {busy, lk_valid}, 2'b00);
      if (aw_cr) check("mon_cr_resp", cr_resp, exp_resp);
      if (lk_valid) begin
        if (aw_rsp || aw_cr || in_data || mq.size() == 0) check("mon_lk_spurious", lk_valid, 1'b0);
        else check("mon_lk_req", {lk_addr, lk_snoop}, {mq[0].addr, mq[0].snoop});
      end
      if (in_data && cd_valid && cd_ready) begin
        beat++;
        if (beat == LB) begin beat = 0; in_data = 0; end
      end
      if (aw_cr && cr_ready) begin
        aw_cr = 0;
        if (exp_resp[0]) begin in_data = 1; beat = 0; end
      end
      if (aw_rsp && lk_rsp_valid) begin
        exp_resp = ref_resp(cur_snoop, lk_hit, lk_dirty, lk_unique);
        aw_rsp = 0; aw_cr = 1;
      end
      if (lk_valid && lk_ready && mq.size() > 0 && !aw_rsp && !aw_cr && !in_data) begin
        cur_snoop = mq[0].snoop;
        void'(mq.pop_front());
        aw_rsp = 1;
      end
      if (ac_valid && ac_ready) mq.push_back('{addr: ac_addr, snoop: ac_snoop});
    end
  end

  typedef struct {
    logic [3:0] snoop;
    logic       hit, dirty, uniq;
    logic [4:0] resp;
    int         beats;
  } vec_t;
  vec_t vecs[8];

  task automatic idle_inputs();
    ac_valid = 0; ac_addr = '0; ac_prot = '0; ac_snoop = '0;
    cr_ready = 0; cd_ready = 0; lk_ready = 0; lk_rsp_valid = 0;
    lk_hit = 0; lk_dirty = 0; lk_unique = 0; ld_valid = 0; ld_data = '0;
  endtask

  // One snoop with all handshakes granted immediately.
  task automatic run_vec(input vec_t v, input int k);
    logic [4:0] got;
    bit seen;
    int beats, last_at;
    @(posedge clk); #1;
    ac_valid = 1; ac_addr = AW'(32'h1000 + k * 64); ac_snoop = v.snoop; ac_prot = 3'($urandom);
    lk_ready = 1; lk_rsp_valid = 1; lk_hit = v.hit; lk_dirty = v.dirty; lk_unique = v.uniq;
    cr_ready = 1; ld_valid = 1; cd_ready = 1; ld_data = {$urandom, $urandom};
    @(posedge clk); #1 ac_valid = 0;
    got = '0; seen = 0; beats = 0; last_at = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (cr_valid && cr_ready) begin got = cr_resp; seen = 1; end
      if (cd_valid && cd_ready) begin beats++; if (cd_last) last_at = beats; end
      if (seen && !busy) break;
      @(posedge clk); #1 ld_data = {$urandom, $urandom};
    end
    check($sformatf("vec%0d_resp", k), got, v.resp);
    check($sformatf("vec%0d_beats", k), beats, v.beats);
    check($sformatf("vec%0d_last_beat", k), last_at, v.beats);
    check($sformatf("vec%0d_busy_end", k), busy, 1'b0);
  endtask

  int n, bt, cnt;

  initial begin
    vecs[0] = '{4'h1, 0, 0, 0, 5'b00000, 0};
    vecs[1] = '{4'h7, 1, 1, 1, 5'b10101, 4};
    vecs[2] = '{4'hD, 1, 1, 1, 5'b10000, 0};
    vecs[3] = '{4'h0, 1, 0, 0, 5'b01000, 0};
    vecs[4] = '{4'h2, 1, 1, 0, 5'b01101, 4};
    vecs[5] = '{4'h1, 1, 1, 1, 5'b11101, 4};
    vecs[6] = '{4'h7, 1, 0, 1, 5'b10000, 0};
    vecs[7] = '{4'h0, 0, 1, 1, 5'b00000, 0};

    idle_inputs();
    resetn = 0;
    #1;
    check("rst_outputs", {cr_valid, cd_valid, lk_valid, ld_ready, busy, cd_last}, 6'b0);
    check("rst_cr_resp", cr_resp, 5'b0);
    check("rst_pending", pending, 3'd0);
    repeat (3) @(posedge clk);
    #2 resetn = 1; mon_en = 1;

    for (int k = 0; k < 8; k++) run_vec(vecs[k], k);

    // Queue fill with the lookup port stalled.
    @(posedge clk); #1;
    lk_ready = 0; lk_rsp_valid = 0; lk_hit = 0; cr_ready = 0;
    ac_valid = 1; ac_snoop = 4'h1; ac_addr = 32'h2000; n = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (ac_ready) n++;
      if (n == 4) break;
      @(posedge clk); #1 ac_addr = AW'(32'h2000 + n * 64);
    end
    @(posedge clk); #1 ac_addr = AW'(32'h2000 + 4 * 64);
    @(negedge clk);
    check("fill_ac_ready_full", ac_ready, 1'b0);
    check("fill_pending_4", pending, 3'd4);
    @(posedge clk); #1 lk_ready = 1;
    @(negedge clk);
    check("fill_head_addr", {lk_valid, lk_addr}, {1'b1, AW'(32'h2000)});
    check("fill_ready_during_pop", ac_ready, 1'b0);
    @(posedge clk); #1 lk_ready = 0;
    @(negedge clk);
    check("fill_ready_after_pop", ac_ready, 1'b1);
    @(posedge clk); #1 ac_valid = 0;
    @(negedge clk);
    check("fill_fifth_accepted", pending, 3'd4);
    @(posedge clk); #1 lk_ready = 1; lk_rsp_valid = 1; cr_ready = 1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (!busy && pending == 0) break;
    end
    check("fill_drained", {busy, pending}, 4'b0);

    // CD backpressure: cd_ready alternates, source holds each beat until taken.
    @(posedge clk); #1;
    ac_valid = 1; ac_addr = 32'h3000; ac_snoop = 4'h7;
    lk_hit = 1; lk_dirty = 1; lk_unique = 1; ld_valid = 1; cd_ready = 0;
    bt = 0; ld_data = 64'hA000;
    @(posedge clk); #1 ac_valid = 0;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      if (cd_valid) begin
        check("bp_data", cd_data, DW'(64'hA000 + bt));
        if (cd_ready) begin
          check("bp_last", cd_last, bt == LB - 1);
          bt++;
        end
      end
      if (bt == LB && !busy) break;
      @(posedge clk); #1 cd_ready = ~cd_ready; ld_data = DW'(64'hA000 + bt);
    end
    check("bp_beats", bt, LB);
    check("bp_idle", busy, 1'b0);

    // Reset while beat 2 is being presented.
    @(posedge clk); #1;
    ac_valid = 1; ac_addr = 32'h4000; ac_snoop = 4'h7; cd_ready = 1; bt = 0;
    @(posedge clk); #1 ac_valid = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (cd_valid && cd_ready) bt++;
      if (bt == 1) break;
    end
    check("rb_first_beat", bt, 1);
    @(posedge clk); #2;
    mon_en = 0; resetn = 0;
    #1;
    check("rb_outputs", {cr_valid, cd_valid, lk_valid, ld_ready, busy, cd_last}, 6'b0);
    check("rb_cr_resp", cr_resp, 5'b0);
    check("rb_pending", pending, 3'd0);
    @(negedge clk);
    @(posedge clk); #2 resetn = 1; mon_en = 1;
    cnt = 0;
    repeat (6) begin
      @(negedge clk);
      if (cd_valid) cnt++;
    end
    check("rb_no_beats_after", cnt, 0);
    run_vec(vecs[1], 8);

    // Random traffic against the model.
    for (int i = 0; i < 2000; i++) begin
      @(posedge clk); #1;
      ac_valid = ($urandom_range(0, 1) == 1);
      ac_addr  = AW'({$urandom} & 32'hFFFF_FFC0);
      case ($urandom_range(0, 5))
        0: ac_snoop = 4'h0;
        1: ac_snoop = 4'h1;
        2: ac_snoop = 4'h2;
        3: ac_snoop = 4'h7;
        4: ac_snoop = 4'hD;
        default: ac_snoop = 4'($urandom);
      endcase
      ac_prot      = 3'($urandom);
      lk_ready     = ($urandom_range(0, 2) != 0);
      lk_rsp_valid = ($urandom_range(0, 2) != 0);
      lk_hit       = ($urandom_range(0, 3) != 0);
      lk_dirty     = ($urandom_range(0, 1) == 1);
      lk_unique    = ($urandom_range(0, 1) == 1);
      cr_ready     = ($urandom_range(0, 2) != 0);
      ld_valid     = ($urandom_range(0, 3) != 0);
      cd_ready     = ($urandom_range(0, 3) != 0);
      ld_data      = {$urandom, $urandom};
    end
    @(posedge clk); #1;
    ac_valid = 0; lk_ready = 1; lk_rsp_valid = 1; cr_ready = 1; ld_valid = 1; cd_ready = 1;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (!busy && pending == 0) break;
    end
    check("rand_drained", {busy, pending}, 4'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
